register_file_multiport: RTL and testbench

- Next-generation RV32I integer register file for the monocycle CPU; replaces the fixed 2-read/4-entry unit.
- Generalised in width, depth and number of read ports.
- Adds hard-wired x0, reset-time stack-pointer initialisation, optional write-to-read bypass, and a sequential bulk-clear engine with busy/done handshake.
- Sits between instruction decode (rs/rd fields) and the ALU/writeback mux.

---
 rtl/register_file_multiport_pkg.sv | 16 +
 rtl/register_file_multiport_if.sv | 31 +++
 rtl/register_file_multiport_clear_engine.sv | 64 ++++++
 rtl/register_file_multiport.sv | 89 ++++++++
 tb/tb_register_file_multiport.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/register_file_multiport_pkg.sv
// Shared types and helpers for the multiport RV32I register file.
package rf_pkg;

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_CLEAR,
    RF_DONE
  } rf_state_t;

  localparam logic [31:0] RF_SP_INIT_DEFAULT = 32'h0000_1000;

  function automatic int unsigned rf_aw(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/register_file_multiport_if.sv
// Decode/writeback-side bus of the register file: read ports, write port, clear handshake.
interface register_file_multiport_if #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned NUM_RD_PORTS = 2
);
  import rf_pkg::*;

  localparam int unsigned AW = rf_aw(NUM_REGS);

  logic [NUM_RD_PORTS*AW-1:0]   rs_addr;
  logic [NUM_RD_PORTS*XLEN-1:0] rs_data;
  logic [AW-1:0]                rd;
  logic [XLEN-1:0]              ru_data_wr;
  logic                         ru_wr;
  logic                         clear_req;
  logic                         clear_busy;
  logic                         clear_done;
  logic                         wr_dropped;

  modport master (
    output rs_addr, rd, ru_data_wr, ru_wr, clear_req,
    input  rs_data, clear_busy, clear_done, wr_dropped
  );

  modport slave (
    input  rs_addr, rd, ru_data_wr, ru_wr, clear_req,
    output rs_data, clear_busy, clear_done, wr_dropped
  );

endinterface

// File: rtl/register_file_multiport_clear_engine.sv
// Sequential bulk-clear engine: walks registers 1..NUM_REGS-1, then pulses done for one cycle.
module rf_clear_engine
  import rf_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned AW       = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear_req,
  output rf_state_t     state,
  output logic [AW-1:0] clr_idx,
  output logic          clr_we,
  output logic          busy,
  output logic          done
);

  logic [AW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RF_IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        RF_IDLE: begin
          done <= 1'b0;
          if (clear_req) begin
            state <= RF_CLEAR;
            count <= AW'(1);
            busy  <= 1'b1;
          end
        end
        RF_CLEAR: begin
          // Exit on the last index so the counter never wraps past NUM_REGS-1.
          if (count == AW'(NUM_REGS - 1)) begin
            state <= RF_DONE;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            count <= count + AW'(1);
          end
        end
        RF_DONE: begin
          state <= RF_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= RF_IDLE;
          count <= '0;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  assign clr_idx = count;
  assign clr_we  = (state == RF_CLEAR);

endmodule

// File: rtl/register_file_multiport.sv
// Parameterised RV32I integer register file: hard-wired x0, SP init, optional bypass, bulk clear.
module register_file_multiport
  import rf_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     NUM_REGS     = 32,
  parameter int unsigned     NUM_RD_PORTS = 2,
  parameter bit              BYPASS       = 1'b1,
  parameter int unsigned     SP_INDEX     = 2,
  parameter logic [XLEN-1:0] SP_INIT      = XLEN'(RF_SP_INIT_DEFAULT)
) (
  input logic                    clk,
  input logic                    rst,
  register_file_multiport_if.slave bus
);

  localparam int unsigned AW    = rf_aw(NUM_REGS);
  localparam bit          SP_EN = (SP_INDEX != 0) && (SP_INDEX < NUM_REGS);

  rf_state_t     state;
  logic [AW-1:0] clr_idx;
  logic          clr_we;
  logic          busy;
  logic          done;
  logic          wr_req;
  logic          wr_en;

  logic [XLEN-1:0] regs [NUM_REGS];

  rf_clear_engine #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW)
  ) u_clear (
    .clk       (clk),
    .rst       (rst),
    .clear_req (bus.clear_req),
    .state     (state),
    .clr_idx   (clr_idx),
    .clr_we    (clr_we),
    .busy      (busy),
    .done      (done)
  );

  assign bus.clear_busy = busy;
  assign bus.clear_done = done;

  assign wr_req = bus.ru_wr && (bus.rd != '0);
  assign wr_en  = wr_req && (state != RF_CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wr_dropped <= 1'b0;
    end else begin
      bus.wr_dropped <= wr_req && (state == RF_CLEAR);
    end
  end

  // Clear writes and port writes are mutually exclusive because port writes are blocked in CLEAR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (SP_EN && (i == SP_INDEX)) ? SP_INIT : '0;
      end
    end else if (clr_we) begin
      regs[clr_idx] <= (SP_EN && (clr_idx == AW'(SP_INDEX))) ? SP_INIT : '0;
    end else if (wr_en) begin
      regs[bus.rd] <= bus.ru_data_wr;
    end
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;

    assign addr = bus.rs_addr[p*AW +: AW];

    always_comb begin
      data = regs[addr];
      if (addr == '0) begin
        data = '0;
      end else if (BYPASS && (state == RF_IDLE) && wr_req && (bus.rd == addr)) begin
        data = bus.ru_data_wr;
      end
    end

    assign bus.rs_data[p*XLEN +: XLEN] = data;
  end

endmodule

// File: tb/tb_register_file_multiport.sv
// Scoreboarded random bench for register_file_multiport (bypass and non-bypass instances).
module tb_register_file_multiport;

  localparam int          XLEN = 32;
  localparam int          NREG = 32;
  localparam int          AW   = 5;
  localparam int          NP   = 2;
  localparam int          SPX  = 2;
  localparam logic [31:0] SPV  = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [NP*AW-1:0] rs_addr   = '0;
  logic [AW-1:0]    rd        = '0;
  logic [31:0]      wdata     = '0;
  logic             ru_wr     = 1'b0;
  logic             clear_req = 1'b0;

  register_file_multiport_if #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_RD_PORTS(NP)) bus_b ();
  register_file_multiport_if #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_RD_PORTS(NP)) bus_n ();

  assign bus_b.rs_addr = rs_addr;    assign bus_n.rs_addr = rs_addr;
  assign bus_b.rd = rd;              assign bus_n.rd = rd;
  assign bus_b.ru_data_wr = wdata;   assign bus_n.ru_data_wr = wdata;
  assign bus_b.ru_wr = ru_wr;        assign bus_n.ru_wr = ru_wr;
  assign bus_b.clear_req = clear_req; assign bus_n.clear_req = clear_req;

  register_file_multiport #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_RD_PORTS(NP), .BYPASS(1'b1),
                            .SP_INDEX(SPX), .SP_INIT(SPV))
    u_dut (.clk(clk), .rst(rst), .bus(bus_b.slave));

  register_file_multiport #(.XLEN(XLEN), .NUM_REGS(NREG), .NUM_RD_PORTS(NP), .BYPASS(1'b0),
                            .SP_INDEX(SPX), .SP_INIT(SPV))
    u_nb (.clk(clk), .rst(rst), .bus(bus_n.slave));

  typedef struct {
    int          cyc;
    int          kind;   // 0 bypass read, 1 busy, 2 done, 3 dropped, 4 non-bypass read
    int          port;
    logic [31:0] want;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: architectural contents plus "clear cycles remaining" bookkeeping.
  logic [31:0] m_regs [NREG];
  int          m_left;
  bit          m_done;
  bit          m_drop;

  function automatic void model_reset();
    for (int i = 0; i < NREG; i++) m_regs[i] = (i == SPX) ? SPV : 32'h0;
    m_left = 0;
    m_done = 1'b0;
    m_drop = 1'b0;
  endfunction

  function automatic logic [31:0] model_read(int a, bit byp);
    bit idle;
    idle = (m_left == 0) && !m_done;
    if (a == 0) return 32'h0;
    if (byp && idle && ru_wr && (int'(rd) == a)) return wdata;
    return m_regs[a];
  endfunction

  function automatic void model_edge();
    int  lb;
    bit  db;
    int  idx;
    lb = m_left;
    db = m_done;
    m_drop = (lb > 0) && ru_wr && (rd != 0);
    if (lb > 0) begin
      idx = NREG - lb;
      m_regs[idx] = (idx == SPX) ? SPV : 32'h0;
      m_left = lb - 1;
      m_done = (m_left == 0);
    end else begin
      if (ru_wr && rd != 0) m_regs[rd] = wdata;
      m_done = 1'b0;
      if (!db && clear_req) m_left = NREG - 1;
    end
  endfunction

  function automatic void push(int kind, int port, logic [31:0] want, string nm);
    exp_t x;
    x.cyc = cyc; x.kind = kind; x.port = port; x.want = want; x.name = nm;
    sb.push_back(x);
  endfunction

  function automatic void expect_cycle();
    int a;
    for (int p = 0; p < NP; p++) begin
      a = int'(rs_addr[p*AW +: AW]);
      push(0, p, model_read(a, 1'b1), $sformatf("rd_byp_p%0d_x%0d", p, a));
      push(4, p, model_read(a, 1'b0), $sformatf("rd_nob_p%0d_x%0d", p, a));
    end
    push(1, 0, {31'h0, m_left > 0}, "clear_busy");
    push(2, 0, {31'h0, m_done}, "clear_done");
    push(3, 0, {31'h0, m_drop}, "wr_dropped");
  endfunction

  task automatic drive(bit w, int a_rd, logic [31:0] d, bit c, int a0, int a1);
    logic [AW-1:0] t0, t1;
    t0 = a0[AW-1:0];
    t1 = a1[AW-1:0];
    ru_wr     = w;
    rd        = a_rd[AW-1:0];
    wdata     = d;
    clear_req = c;
    rs_addr   = {t1, t0};
    expect_cycle();
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    ru_wr     = 1'b0;
    clear_req = 1'b0;
    model_reset();
    expect_cycle();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic int ra();
    return int'($urandom_range(0, NREG - 1));
  endfunction

  exp_t        cur;
  logic [31:0] act;

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      cur = sb.pop_front();
      case (cur.kind)
        0:       act = bus_b.rs_data[cur.port*XLEN +: XLEN];
        4:       act = bus_n.rs_data[cur.port*XLEN +: XLEN];
        1:       act = {31'h0, bus_b.clear_busy};
        2:       act = {31'h0, bus_b.clear_done};
        default: act = {31'h0, bus_b.wr_dropped};
      endcase
      checks++;
      if (cur.cyc != cyc || act !== cur.want) begin
        errors++;
        $display("FAIL %s cyc=%0d got=%h want=%h", cur.name, cur.cyc, act, cur.want);
      end
    end
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    drive(0, 0, 0, 0, 0, 2);
    drive(0, 0, 0, 0, 5, 2);
    drive(1, 5, 32'hDEAD_BEEF, 0, 5, 2);
    drive(0, 0, 0, 0, 5, 0);
    drive(1, 0, 32'hFFFF_FFFF, 0, 0, 5);
    drive(0, 0, 0, 0, 0, 5);

    for (int i = 0; i < 150; i++)
      drive(bit'($urandom_range(0, 1)), ra(), $urandom, 0, ra(), ra());

    for (int i = 1; i < NREG; i++) drive(1, i, 32'(i * 3), 0, ra(), i);
    drive(0, 0, 0, 1, 2, 7);
    for (int k = 1; k < NREG; k++) begin
      if (k == 7)       drive(1, 7, 32'h55, 0, 7, 3);
      else if (k == 12) drive(1, 0, 32'h123, 0, 0, 7);
      else              drive(bit'($urandom_range(0, 1)), ra(), $urandom,
                              bit'($urandom_range(0, 1)), ra(), ra());
    end
    drive(1, 7, 32'h55, 1, 7, 2);
    drive(0, 0, 0, 0, 7, 2);
    for (int i = 0; i < NREG; i += 2) drive(0, 0, 0, 0, i, i + 1);

    for (int i = 1; i < 8; i++) drive(1, i, $urandom, 0, i, 2);
    drive(0, 0, 0, 1, 3, 4);
    for (int k = 1; k < 10; k++) drive(0, 0, 0, 0, k, 30);
    do_reset();
    for (int i = 0; i < NREG; i += 2) drive(0, 0, 0, 0, i, i + 1);

    for (int i = 0; i < 400; i++)
      drive(bit'($urandom_range(0, 1)), ra(), $urandom,
            $urandom_range(0, 19) == 0, ra(), ra());

    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d want=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
